// File: rtl/counter_updown_monitor.sv
// -----------------------------------------------------------------------------
// counter_updown_monitor
//
// In-line hardware checker for an up/down counter. It snoops the counter's
// control inputs and its count/carry outputs, steps a reference model in
// lock-step, and flags every cycle where the counter disagrees with the model.
// The first mismatch is captured (expected and actual count). Error and check
// counters saturate instead of wrapping.
//
// Optional feature (compile-time macro):
//   COUNTER_MON_STOP_ON_ERR_EN
//     defined   : the first mismatch moves TRACK to HALT. HALT freezes the
//                 model and all status, and only reset, clear or enable=0
//                 leave it.
//     undefined : HALT is unreachable; the monitor resyncs and keeps counting.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset of the monitor only
//   enable        in   1 = checking active, 0 = IDLE
//   clear         in   synchronous clear of error status, re-enters SYNC
//   mon_reset_n   in   snooped counter reset_n
//   mon_load      in   snooped counter load
//   mon_in        in   snooped counter load data [WIDTH]
//   mon_up_down   in   snooped counter direction (1 = up)
//   mon_count_en  in   snooped counter count enable
//   mon_count     in   snooped counter count output [WIDTH]
//   mon_carry     in   snooped counter carry output
//   state         out  0 IDLE, 1 SYNC, 2 TRACK, 3 HALT
//   err_flag      out  sticky, set on first mismatch
//   err_count     out  mismatching cycles, saturating [ERR_CNT_W]
//   chk_count     out  cycles compared in TRACK, saturating [ERR_CNT_W]
//   first_exp     out  model count at first mismatch [WIDTH]
//   first_act     out  counter count at first mismatch [WIDTH]
// -----------------------------------------------------------------------------
module counter_updown_monitor #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 mon_reset_n,
  input  logic                 mon_load,
  input  logic [WIDTH-1:0]     mon_in,
  input  logic                 mon_up_down,
  input  logic                 mon_count_en,
  input  logic [WIDTH-1:0]     mon_count,
  input  logic                 mon_carry,
  output logic [1:0]           state,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ERR_CNT_W-1:0] chk_count,
  output logic [WIDTH-1:0]     first_exp,
  output logic [WIDTH-1:0]     first_act
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_TRACK = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]     CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0]     CNT_ONES = {WIDTH{1'b1}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE  = ERR_CNT_W'(1);

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       exp_q, exp_d;
  logic                   err_flag_q, err_flag_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
  logic [ERR_CNT_W-1:0]   chk_count_q, chk_count_d;
  logic [WIDTH-1:0]       first_exp_q, first_exp_d;
  logic [WIDTH-1:0]       first_act_q, first_act_d;

  logic                   exp_carry;
  logic                   mismatch;
  logic [WIDTH-1:0]       nxt_count;
  logic [WIDTH-1:0]       nxt_exp;

  // One step of the counter as seen from its snooped controls, applied to an
  // arbitrary base value (either the model or the observed count).
  function automatic logic [WIDTH-1:0] step_fn(
    input logic [WIDTH-1:0] b,
    input logic             rst_n,
    input logic             ld,
    input logic [WIDTH-1:0] din,
    input logic             up,
    input logic             cen
  );
    if (!rst_n)   return '0;
    else if (ld)  return din;
    else if (cen) return up ? (b + CNT_ONE) : (b - CNT_ONE);
    return b;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : (v + ERR_ONE);
  endfunction

  always_comb begin
    exp_carry = mon_up_down ? (exp_q == CNT_ONES) : (exp_q == '0);
    mismatch  = (mon_count != exp_q) || (mon_carry != exp_carry);
    nxt_count = step_fn(mon_count, mon_reset_n, mon_load, mon_in, mon_up_down, mon_count_en);
    nxt_exp   = step_fn(exp_q,     mon_reset_n, mon_load, mon_in, mon_up_down, mon_count_en);
  end

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    chk_count_d = chk_count_q;
    first_exp_d = first_exp_q;
    first_act_d = first_act_q;

    if (clear) begin
      // Any mismatch seen in this cycle is dropped along with the old status.
      err_flag_d  = 1'b0;
      err_count_d = '0;
      chk_count_d = '0;
      first_exp_d = '0;
      first_act_d = '0;
      exp_d       = '0;
      state_d     = enable ? S_SYNC : S_IDLE;
    end else if (!enable) begin
      // Status is kept so it can be read out while checking is paused.
      exp_d   = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          exp_d   = '0;
          state_d = S_SYNC;
        end
        S_SYNC: begin
          // Adopt whatever the counter shows now; checking starts next cycle.
          exp_d   = nxt_count;
          state_d = S_TRACK;
        end
        S_TRACK: begin
          if (!mon_reset_n) begin
            // Counter is being reset: its outputs are not meaningful yet.
            exp_d = '0;
          end else begin
            chk_count_d = sat_inc(chk_count_q);
            if (mismatch) begin
              err_flag_d  = 1'b1;
              err_count_d = sat_inc(err_count_q);
              if (!err_flag_q) begin
                first_exp_d = exp_q;
                first_act_d = mon_count;
              end
              // Resync to the observed value so a single jump counts once.
              exp_d = nxt_count;
`ifdef COUNTER_MON_STOP_ON_ERR_EN
              state_d = S_HALT;
`endif
            end else begin
              exp_d = nxt_exp;
            end
          end
        end
        S_HALT: begin
`ifdef COUNTER_MON_STOP_ON_ERR_EN
          // Everything frozen until clear, enable=0 or reset.
          state_d = S_HALT;
`else
          // Not reachable in this build; recover by resyncing.
          state_d = S_SYNC;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      exp_q       <= '0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
      chk_count_q <= '0;
      first_exp_q <= '0;
      first_act_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
      chk_count_q <= chk_count_d;
      first_exp_q <= first_exp_d;
      first_act_q <= first_act_d;
    end
  end

  assign state     = state_q;
  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;
  assign chk_count = chk_count_q;
  assign first_exp = first_exp_q;
  assign first_act = first_act_q;

endmodule
